// File: rtl/sram_bus_pkg.sv
// ---------------------------------------------------------------------------
// sram_bus_pkg
// Shared definitions for clients of the single-port SRAM arbiter.
//   ADDRESS_BUS_WIDTH_DEFAULT : default SRAM word address width
//   DATA_BUS_WIDTH_DEFAULT    : default SRAM word width
//   reader_state_e            : stream reader FSM encoding
//                               (IDLE=0, FETCH=1, DRAIN=2, DONE=3)
// ---------------------------------------------------------------------------
package sram_bus_pkg;

  localparam int ADDRESS_BUS_WIDTH_DEFAULT = 12;
  localparam int DATA_BUS_WIDTH_DEFAULT    = 16;

  localparam logic [1:0] STATE_IDLE  = 2'd0;
  localparam logic [1:0] STATE_FETCH = 2'd1;
  localparam logic [1:0] STATE_DRAIN = 2'd2;
  localparam logic [1:0] STATE_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = STATE_IDLE,
    FETCH = STATE_FETCH,
    DRAIN = STATE_DRAIN,
    DONE  = STATE_DONE
  } reader_state_e;

endpackage

// File: rtl/sram_reader_fifo.sv
// ---------------------------------------------------------------------------
// sram_reader_fifo
// Small synchronous FIFO shared by SRAM bus clients. Head word is presented
// combinationally on pop_data. A push on a full FIFO is accepted only when a
// pop happens in the same cycle (occupancy then stays unchanged).
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset (flushes FIFO)
//   push, push_data   : write request and word
//   pop               : remove head word (ignored when empty)
//   pop_data          : current head word (zero after reset)
//   full, empty, count: occupancy status
// ---------------------------------------------------------------------------
module sram_reader_fifo #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/sram_stream_reader.sv
// ---------------------------------------------------------------------------
// sram_stream_reader
// Requester-side client for one slot of the shared single-port SRAM arbiter.
// Fetches word_count consecutive words from base_address, one outstanding
// read at a time, buffers them in a FIFO and streams them out over
// valid/ready. Address wraps modulo 2^ADDRESS_BUS_WIDTH.
// Ports:
//   clk, rst             : clock, asynchronous active-low reset
//   start, base_address,
//   word_count           : block fetch command (sampled when idle)
//   busy, done           : status; done pulses after the last word is popped
//   read_request,
//   read_address         : request to the arbiter slot
//   read_finished_strobe,
//   read_data            : completion strobe and data from the arbiter
//   out_data, out_valid,
//   out_ready            : downstream stream
// Optional build macro SRAM_STREAM_READER_LOOP_EN adds input 'loop': when
// set at start, the block is re-fetched continuously until loop drops, after
// which the current pass completes normally.
// ---------------------------------------------------------------------------
module sram_stream_reader
  import sram_bus_pkg::*;
#(
  parameter int ADDRESS_BUS_WIDTH = ADDRESS_BUS_WIDTH_DEFAULT,
  parameter int DATA_BUS_WIDTH    = DATA_BUS_WIDTH_DEFAULT,
  parameter int FIFO_DEPTH        = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [ADDRESS_BUS_WIDTH-1:0] base_address,
  input  logic [ADDRESS_BUS_WIDTH:0]   word_count,
`ifdef SRAM_STREAM_READER_LOOP_EN
  input  logic                         loop,
`endif
  output logic                         busy,
  output logic                         done,
  output logic                         read_request,
  output logic [ADDRESS_BUS_WIDTH-1:0] read_address,
  input  logic                         read_finished_strobe,
  input  logic [DATA_BUS_WIDTH-1:0]    read_data,
  output logic [DATA_BUS_WIDTH-1:0]    out_data,
  output logic                         out_valid,
  input  logic                         out_ready
);

  localparam int AW    = ADDRESS_BUS_WIDTH;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  reader_state_e     state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [AW:0]       remaining_q, remaining_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              req_pending_q, req_pending_d;
`ifdef SRAM_STREAM_READER_LOOP_EN
  logic [AW-1:0]     base_q, base_d;
  logic [AW:0]       count_q, count_d;
  logic              loop_q, loop_d;
`endif

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              strobe_hit;
  logic              slot_free;

  sram_reader_fifo #(
    .WIDTH (DATA_BUS_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .push      (fifo_push),
    .push_data (read_data),
    .pop       (fifo_pop),
    .pop_data  (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Strobes are only meaningful while our own read is outstanding; anything
  // else (idle, after reset, between requests) is dropped.
  assign strobe_hit = read_finished_strobe & req_pending_q & (state_q == FETCH);
  assign fifo_push  = strobe_hit;
  assign fifo_pop   = out_ready & ~fifo_empty;

  // An outstanding read already holds a slot, so a new request is raised only
  // when none is pending; a pop this cycle counts as a freed slot.
  assign slot_free = (fifo_count < CNT_W'(FIFO_DEPTH)) | fifo_pop;

  // Masking with the strobe keeps the arbiter from seeing a stale request in
  // the completion cycle.
  assign read_request = req_pending_q & ~read_finished_strobe;
  assign read_address = addr_q;
  assign out_valid    = ~fifo_empty;
  assign busy         = busy_q;
  assign done         = done_q;

  // Next-state logic; done is registered so it rises on the same edge that
  // busy falls when leaving DONE.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    remaining_d   = remaining_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    req_pending_d = req_pending_q;
`ifdef SRAM_STREAM_READER_LOOP_EN
    base_d        = base_q;
    count_d       = count_q;
    loop_d        = loop_q & loop;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d      = base_address;
          remaining_d = word_count;
          busy_d      = 1'b1;
`ifdef SRAM_STREAM_READER_LOOP_EN
          base_d      = base_address;
          count_d     = word_count;
          loop_d      = loop;
`endif
          state_d     = (word_count == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        if (strobe_hit) begin
          req_pending_d = 1'b0;
          addr_d        = addr_q + 1'b1;
          remaining_d   = remaining_q - 1'b1;
          if (remaining_q == (AW+1)'(1)) begin
`ifdef SRAM_STREAM_READER_LOOP_EN
            if (loop_q & loop) begin
              addr_d      = base_q;
              remaining_d = count_q;
            end else begin
              state_d = DRAIN;
            end
`else
            state_d = DRAIN;
`endif
          end
        end else if (!req_pending_q && slot_free) begin
          req_pending_d = 1'b1;
        end
      end
      DRAIN: begin
        if (fifo_empty) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      remaining_q   <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      req_pending_q <= 1'b0;
`ifdef SRAM_STREAM_READER_LOOP_EN
      base_q        <= '0;
      count_q       <= '0;
      loop_q        <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      remaining_q   <= remaining_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      req_pending_q <= req_pending_d;
`ifdef SRAM_STREAM_READER_LOOP_EN
      base_q        <= base_d;
      count_q       <= count_d;
      loop_q        <= loop_d;
`endif
    end
  end

endmodule

// File: tb/tb_sram_stream_reader.sv
// ---------------------------------------------------------------------------
// tb_sram_stream_reader
// Directed bench for sram_stream_reader with a behavioural arbiter slot that
// strobes data three clocks after seeing a request. Returned data for
// address a is {4'h0,a} ^ 16'hBEFF (0x010 -> 0xBEEF).
// ---------------------------------------------------------------------------
module tb_sram_stream_reader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [11:0] base_address;
  logic [12:0] word_count;
  logic        busy;
  logic        done;
  logic        read_request;
  logic [11:0] read_address;
  logic        read_finished_strobe;
  logic [15:0] read_data;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;

  logic        arb_strobe;
  logic        spur_strobe;
  logic        arb_active;
  logic [11:0] arb_addr;

  int          assert_count;
  int          fail_count;
  int          grant_count;
  int          pop_count;
  int          done_count;
  logic [11:0] grant_addr [64];
  logic [15:0] pop_data   [64];

  assign read_finished_strobe = arb_strobe | spur_strobe;

  sram_stream_reader #(
    .ADDRESS_BUS_WIDTH (12),
    .DATA_BUS_WIDTH    (16),
    .FIFO_DEPTH        (4)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .start                (start),
    .base_address         (base_address),
    .word_count           (word_count),
`ifdef SRAM_STREAM_READER_LOOP_EN
    .loop                 (1'b0),
`endif
    .busy                 (busy),
    .done                 (done),
    .read_request         (read_request),
    .read_address         (read_address),
    .read_finished_strobe (read_finished_strobe),
    .read_data            (read_data),
    .out_data             (out_data),
    .out_valid            (out_valid),
    .out_ready            (out_ready)
  );

  // 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something blocks forever
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [15:0] dataOf(input logic [11:0] a);
    return {4'h0, a} ^ 16'hBEFF;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assert_count++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Issues a one-cycle start pulse, accepted on the posedge inside the task
  task automatic applyStimulus(input logic [11:0] base, input logic [12:0] count);
    @(posedge clk); #1;
    base_address = base;
    word_count   = count;
    start        = 1'b1;
    @(posedge clk); #1;
    start        = 1'b0;
  endtask

  task automatic setReady(input logic r);
    @(posedge clk); #1;
    out_ready = r;
  endtask

  task automatic waitDone(input string tag, input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, done, 1);
  endtask

  // Arbiter slot model: grant a seen request, strobe three clocks later
  always begin
    @(negedge clk);
    if (read_request) begin
      arb_active = 1'b1;
      arb_addr   = read_address;
      if (grant_count < 64) grant_addr[grant_count] = read_address;
      grant_count++;
      repeat (2) @(negedge clk);
      if (rst) checkOutput("addr_stable", read_address, arb_addr);
      read_data  = dataOf(arb_addr);
      arb_strobe = 1'b1;
      #1;
      checkOutput("strobe_mask", read_request, 0);
      @(negedge clk);
      arb_strobe = 1'b0;
      arb_active = 1'b0;
    end
  end

  // Consumer and done monitors
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (pop_count < 64) pop_data[pop_count] = out_data;
      pop_count++;
    end
    if (done) done_count++;
  end

  initial begin
    int g0;
    int p0;
    int d0;
    int n;
    logic [11:0] wrap_addr [4];

    assert_count = 0;
    fail_count   = 0;
    grant_count  = 0;
    pop_count    = 0;
    done_count   = 0;
    rst          = 1'b0;
    start        = 1'b0;
    base_address = '0;
    word_count   = '0;
    out_ready    = 1'b0;
    arb_strobe   = 1'b0;
    spur_strobe  = 1'b0;
    arb_active   = 1'b0;
    arb_addr     = '0;
    read_data    = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_req", read_request, 0);
    checkOutput("rst_addr", read_address, 0);
    checkOutput("rst_valid", out_valid, 0);
    checkOutput("rst_data", out_data, 0);
    rst = 1'b1;

    // Single word
    $display("[TB] single word");
    g0 = grant_count; p0 = pop_count; d0 = done_count;
    applyStimulus(12'h010, 13'd1);
    checkOutput("single_busy", busy, 1);
    n = 0;
    while (!out_valid && n < 30) begin @(negedge clk); n++; end
    checkOutput("single_valid", out_valid, 1);
    checkOutput("single_data", out_data, 16'hBEEF);
    checkOutput("single_grants", grant_count - g0, 1);
    checkOutput("single_addr", grant_addr[g0], 12'h010);
    checkOutput("single_no_done", done_count - d0, 0);
    setReady(1'b1);
    waitDone("single_done", 30);
    checkOutput("single_busy_low", busy, 0);
    checkOutput("single_pops", pop_count - p0, 1);
    checkOutput("single_pop_data", pop_data[p0], 16'hBEEF);
    @(posedge clk); #1;
    checkOutput("single_done_pulse", done, 0);

    // Back-pressure
    $display("[TB] back-pressure");
    setReady(1'b0);
    g0 = grant_count; p0 = pop_count;
    applyStimulus(12'h010, 13'd8);
    repeat (40) @(negedge clk);
    checkOutput("bp_grants_full", grant_count - g0, 4);
    checkOutput("bp_req_low", read_request, 0);
    checkOutput("bp_valid", out_valid, 1);
    checkOutput("bp_hold", out_data, 16'hBEEF);
    setReady(1'b1);
    waitDone("bp_done", 300);
    checkOutput("bp_grants", grant_count - g0, 8);
    checkOutput("bp_pops", pop_count - p0, 8);
    for (int i = 0; i < 8; i++) begin
      checkOutput("bp_addr", grant_addr[g0 + i], 12'h010 + 12'(i));
      checkOutput("bp_data", pop_data[p0 + i], dataOf(12'h010 + 12'(i)));
    end

    // Address wrap
    $display("[TB] wrap");
    wrap_addr[0] = 12'hFFE; wrap_addr[1] = 12'hFFF;
    wrap_addr[2] = 12'h000; wrap_addr[3] = 12'h001;
    g0 = grant_count; p0 = pop_count;
    applyStimulus(12'hFFE, 13'd4);
    waitDone("wrap_done", 200);
    checkOutput("wrap_grants", grant_count - g0, 4);
    for (int i = 0; i < 4; i++) begin
      checkOutput("wrap_addr", grant_addr[g0 + i], wrap_addr[i]);
    end
    checkOutput("wrap_data0", pop_data[p0], 16'hB101);

    // Zero count
    $display("[TB] zero count");
    g0 = grant_count;
    applyStimulus(12'h055, 13'd0);
    checkOutput("zero_busy", busy, 1);
    checkOutput("zero_done_early", done, 0);
    checkOutput("zero_req", read_request, 0);
    @(posedge clk); #1;
    checkOutput("zero_busy_low", busy, 0);
    checkOutput("zero_done", done, 1);
    @(posedge clk); #1;
    checkOutput("zero_done_once", done, 0);
    checkOutput("zero_grants", grant_count - g0, 0);

    // Spurious strobe while idle
    $display("[TB] spurious strobe");
    @(posedge clk); #1; spur_strobe = 1'b1;
    @(posedge clk); #1; spur_strobe = 1'b0;
    @(negedge clk);
    checkOutput("spur_valid", out_valid, 0);
    checkOutput("spur_busy", busy, 0);
    checkOutput("spur_req", read_request, 0);

    // Reset mid-fetch with two words buffered and a read outstanding
    $display("[TB] reset mid-fetch");
    setReady(1'b0);
    g0 = grant_count;
    applyStimulus(12'h030, 13'd8);
    n = 0;
    while (grant_count < g0 + 3 && n < 100) begin @(negedge clk); n++; end
    #2;
    checkOutput("mid_third_grant", grant_count - g0, 3);
    checkOutput("mid_req_pre", read_request, 1);
    checkOutput("mid_valid_pre", out_valid, 1);
    rst = 1'b0;
    #1;
    checkOutput("mid_req", read_request, 0);
    checkOutput("mid_valid", out_valid, 0);
    checkOutput("mid_busy", busy, 0);
    checkOutput("mid_data", out_data, 0);
    n = 0;
    while (arb_active && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("post_valid", out_valid, 0);
    checkOutput("post_req", read_request, 0);
    g0 = grant_count; p0 = pop_count;
    setReady(1'b1);
    applyStimulus(12'h020, 13'd2);
    waitDone("post_done", 100);
    checkOutput("post_grants", grant_count - g0, 2);
    checkOutput("post_addr0", grant_addr[g0], 12'h020);
    checkOutput("post_addr1", grant_addr[g0 + 1], 12'h021);
    checkOutput("post_pops", pop_count - p0, 2);
    checkOutput("post_data0", pop_data[p0], 16'hBEDF);
    checkOutput("post_data1", pop_data[p0 + 1], 16'hBEDE);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/sram_stream_reader.md
Name: sram_stream_reader

Overview:
Requester-side client for the shared single-port SRAM arbiter: owns one read_request/read_finished_strobe slot.
- Fetches a block of consecutive words starting at a base address, one outstanding read at a time.
- Buffers returned words in a small FIFO.
- Presents them to a downstream consumer (e.g. an LED output channel) over a valid/ready stream.

Parameters:
ADDRESS_BUS_WIDTH, 12, SRAM word address width
DATA_BUS_WIDTH, 16, SRAM word width
FIFO_DEPTH, 4, output buffer depth in words; power of two, >= 2

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset (asserted when 0)
start  input  1  one-cycle pulse; begins a block fetch when idle
base_address  input  ADDRESS_BUS_WIDTH  first word address, sampled on accepted start
word_count  input  ADDRESS_BUS_WIDTH+1  words to fetch, sampled on accepted start
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse when last word has left the FIFO
read_request  output  1  request line to arbiter slot
read_address  output  ADDRESS_BUS_WIDTH  address for current request, stable while read_request high
read_finished_strobe  input  1  this slot's completion strobe from arbiter
read_data  input  DATA_BUS_WIDTH  shared arbiter data bus, valid only with read_finished_strobe
out_data  output  DATA_BUS_WIDTH  FIFO head word
out_valid  output  1  FIFO non-empty
out_ready  input  1  consumer accepts out_data when out_valid && out_ready

Behaviour:
- Reset (rst=0, async): state IDLE, busy=0, done=0, read_request=0, read_address=0, out_valid=0, out_data=0, FIFO flushed, counters 0. Reset mid-fetch abandons the block; a strobe arriving after reset release while IDLE is ignored.
- States: IDLE, FETCH, DRAIN, DONE.
- IDLE: start=1 latches base_address into addr and word_count into remaining; busy<=1.
  - word_count=0 -> DONE.
  - Otherwise -> FETCH.
  - start while busy is ignored.
- FETCH:
  - Internal req_pending is set when no read is outstanding and FIFO free slots > 0. Free slots = FIFO_DEPTH - occupancy, with an outstanding read counted as occupied.
  - read_request = req_pending & ~read_finished_strobe (combinational mask). The arbiter must never see a stale request in the cycle after completion; no duplicate reads are permitted.
  - read_address = addr.
  - On read_finished_strobe: push read_data into FIFO the same edge; clear req_pending; addr<=addr+1 (modulo 2^ADDRESS_BUS_WIDTH, 0xFFF wraps to 0x000); remaining<=remaining-1. If remaining was 1 -> DRAIN.
  - Strobe while req_pending=0 is ignored; no push.
- FIFO full: no new request is raised; resumes the cycle after a pop frees a slot. Overflow is impossible by construction.
- DRAIN: wait until FIFO empty -> DONE.
- DONE: done=1 for exactly one cycle, busy<=0 -> IDLE. busy falls the same edge done rises.
- Pop and push in the same cycle on a full FIFO are both legal; occupancy is unchanged.
- Latency: out_valid rises the cycle after the first read_finished_strobe. Throughput is bounded by the arbiter (at least 3 clocks per word).
- out_data holds when out_valid=1 and out_ready=0.

Optional Feature:
SRAM_STREAM_READER_LOOP_EN
- Defined: adds input loop (1 bit), sampled at start. With loop=1, on the last strobe addr reloads base_address and remaining reloads word_count. FETCH continues indefinitely with no DRAIN and no done pulse. Deasserting loop finishes the current pass, then proceeds normally.
- Undefined: no loop port; single-pass only.

Decomposition:
- Package sram_bus_pkg holds:
  - default ADDRESS_BUS_WIDTH / DATA_BUS_WIDTH constants;
  - the state encoding localparams (IDLE=0, FETCH=1, DRAIN=2, DONE=3).
- Sub-module sram_reader_fifo: synchronous FIFO with push, pop, full, empty, count, async active-low reset. It is shared with other bus clients.

Test Plan:
- Single word: start, base=0x010, count=1, arbiter model strobes with data 0xBEEF 3 cycles after request -> exactly one request at address 0x010, out_data=0xBEEF, done pulse after pop, busy 0.
- Back-pressure: count=8, out_ready=0, FIFO_DEPTH=4 -> exactly 4 requests, then read_request stays 0. Raise out_ready -> remaining 4 fetched in order, addresses 0x010..0x017, no duplicates.
- Wrap: base=0xFFE, count=4 -> addresses 0xFFE, 0xFFF, 0x000, 0x001 in order.
- Zero count: start with count=0 -> no request; done one cycle later; busy high for exactly one cycle.
- Strobe masking: strobe issued while request high -> read_request low in the strobe cycle, arbiter model records exactly word_count grants. A spurious strobe in IDLE leaves FIFO empty.
- Reset mid-fetch: rst=0 asynchronously while request outstanding with 2 words in FIFO -> read_request, out_valid, busy drop before next clock edge. After release, a new start (count=2) completes normally.
